// File: rtl/simple_spi_slave_if.sv
// ============================================================================
// Module     : simple_spi_slave_if
// Description: SPI pin bundle plus parallel word/strobe side of the SPI slave.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simple_spi_slave_if #(
  parameter int WIDTH = 8
);
  logic             pin_ncs;
  logic             pin_clk;
  logic             pin_mosi;
  logic             pin_miso;
  logic             pin_miso_en;
  logic [WIDTH-1:0] value_miso;
  logic [WIDTH-1:0] value_mosi;
  logic             cs_start;
  logic             cs_stop;
  logic             value_valid;

  modport slave (
    input  pin_ncs, pin_clk, pin_mosi, value_miso,
    output pin_miso, pin_miso_en, value_mosi, cs_start, cs_stop, value_valid
  );

  modport master (
    output pin_ncs, pin_clk, pin_mosi, value_miso,
    input  pin_miso, pin_miso_en, value_mosi, cs_start, cs_stop, value_valid
  );
endinterface

`default_nettype wire

// File: rtl/simple_spi_slave.sv
// ============================================================================
// Module     : simple_spi_slave
// Description: SPI mode-0 slave, MSB first, oversampled in the system_clk domain.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_spi_slave #(
  parameter int WIDTH = 8
) (
  input  logic                system_clk,
  input  logic                rst,
  simple_spi_slave_if.slave   bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // [0] first sync stage, [1] synced value, [2] history for edge detection
  logic [2:0]       ncs_sync_q, ncs_sync_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       mosi_sync_q, mosi_sync_d;

  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] value_mosi_q, value_mosi_d;
  logic             valid_q, valid_d;
  logic             cs_start_q, cs_start_d;
  logic             cs_stop_q, cs_stop_d;
  logic             pin_miso_q, pin_miso_d;
  logic             pin_miso_en_q, pin_miso_en_d;

  logic             w_ncs;
  logic             w_ncs_hist;
  logic             w_ncs_fall;
  logic             w_ncs_rise;
  logic             w_sck_rise;
  logic             w_sck_fall;

  assign w_ncs      = ncs_sync_q[1];
  assign w_ncs_hist = ncs_sync_q[2];
  assign w_ncs_fall = w_ncs_hist & ~w_ncs;
  assign w_ncs_rise = ~w_ncs_hist & w_ncs;
  // Rise qualified by the previous select state so a final SCK rise still
  // completes its word when ncs rises in the same cycle.
  assign w_sck_rise = clk_sync_q[1] & ~clk_sync_q[2] & ~w_ncs_hist;
  assign w_sck_fall = ~clk_sync_q[1] & clk_sync_q[2] & ~w_ncs;

  always_comb begin
    ncs_sync_d   = {ncs_sync_q[1:0], bus.pin_ncs};
    clk_sync_d   = {clk_sync_q[1:0], bus.pin_clk};
    mosi_sync_d  = {mosi_sync_q[0], bus.pin_mosi};
    rx_d         = rx_q;
    tx_d         = tx_q;
    cnt_d        = cnt_q;
    value_mosi_d = value_mosi_q;
    valid_d      = 1'b0;
    cs_start_d   = 1'b0;
    cs_stop_d    = 1'b0;

    if (w_sck_rise) begin
      rx_d = {rx_q[WIDTH-2:0], mosi_sync_q[1]};
      if (cnt_q == LAST_BIT) begin
        cnt_d        = '0;
        value_mosi_d = rx_d;
        valid_d      = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (w_ncs_fall) begin
      cs_start_d = 1'b1;
      cnt_d      = '0;
      rx_d       = '0;
      tx_d       = bus.value_miso;
    end else if (w_sck_fall) begin
      // Word boundary: fetch the next word so back-to-back words need no ncs toggle
      tx_d = (cnt_q == '0) ? bus.value_miso : {tx_q[WIDTH-2:0], 1'b0};
    end

    if (w_ncs_rise) begin
      cs_stop_d = 1'b1;
      cnt_d     = '0;
    end

    pin_miso_en_d = ~w_ncs;
    pin_miso_d    = ~w_ncs & tx_d[WIDTH-1];
  end

  always_ff @(posedge system_clk) begin
    if (rst) begin
      ncs_sync_q    <= 3'b111;
      clk_sync_q    <= 3'b000;
      mosi_sync_q   <= 2'b00;
      rx_q          <= '0;
      tx_q          <= '0;
      cnt_q         <= '0;
      value_mosi_q  <= '0;
      valid_q       <= 1'b0;
      cs_start_q    <= 1'b0;
      cs_stop_q     <= 1'b0;
      pin_miso_q    <= 1'b0;
      pin_miso_en_q <= 1'b0;
    end else begin
      ncs_sync_q    <= ncs_sync_d;
      clk_sync_q    <= clk_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      cnt_q         <= cnt_d;
      value_mosi_q  <= value_mosi_d;
      valid_q       <= valid_d;
      cs_start_q    <= cs_start_d;
      cs_stop_q     <= cs_stop_d;
      pin_miso_q    <= pin_miso_d;
      pin_miso_en_q <= pin_miso_en_d;
    end
  end

  assign bus.pin_miso    = pin_miso_q;
  assign bus.pin_miso_en = pin_miso_en_q;
  assign bus.value_mosi  = value_mosi_q;
  assign bus.value_valid = valid_q;
  assign bus.cs_start    = cs_start_q;
  assign bus.cs_stop     = cs_stop_q;

endmodule

`default_nettype wire

// File: tb/tb_simple_spi_slave.sv
// ============================================================================
// Module     : tb_simple_spi_slave
// Description: Directed self-checking bench for simple_spi_slave (WIDTH=4).
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/100ps

module tb_simple_spi_slave;

  localparam int WIDTH = 4;

  logic system_clk = 1'b0;
  logic rst        = 1'b1;
  int   n_cmp      = 0;
  int   n_mis      = 0;
  int   n_valid    = 0;
  int   n_start    = 0;
  int   n_stop     = 0;

  simple_spi_slave_if #(.WIDTH(WIDTH)) bus ();

  simple_spi_slave #(.WIDTH(WIDTH)) dut (
    .system_clk (system_clk),
    .rst        (rst),
    .bus        (bus)
  );

  always #1 system_clk = ~system_clk;

  always @(negedge system_clk) begin
    if (bus.value_valid) n_valid++;
    if (bus.cs_start)    n_start++;
    if (bus.cs_stop)     n_stop++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Master side of one word; nxt is presented on value_miso after the last rise.
  task automatic xfer(input logic [3:0] mo, input logic [3:0] nxt, output logic [3:0] mi);
    for (int i = 3; i >= 0; i--) begin
      bus.pin_mosi = mo[i];
      #100;
      mi[i] = bus.pin_miso;
      bus.pin_clk = 1'b1;
      #100;
      if (i == 0) bus.value_miso = nxt;
      bus.pin_clk = 1'b0;
    end
  endtask

  task automatic frame(input logic [3:0] mi_word, input logic [3:0] mo_word, output logic [3:0] got);
    bus.value_miso = mi_word;
    bus.pin_ncs    = 1'b0;
    #100;
    xfer(mo_word, mi_word, got);
    #100;
    bus.pin_ncs = 1'b1;
    #100;
  endtask

  initial begin
    logic [3:0] got, got2;
    logic [3:0] miso_tab [7];
    logic [3:0] mosi_tab [7];
    int v0, s0, p0;

    miso_tab = '{4'b0000, 4'b1111, 4'b0101, 4'b0001, 4'b1000, 4'b1110, 4'b0111};
    mosi_tab = '{4'b1111, 4'b0000, 4'b1010, 4'b1000, 4'b0001, 4'b0111, 4'b1110};

    bus.pin_ncs    = 1'b1;
    bus.pin_clk    = 1'b0;
    bus.pin_mosi   = 1'b0;
    bus.value_miso = 4'b0000;
    #0.5;
    #10;
    rst = 1'b0;
    #10;
    check("reset_miso",    {31'd0, bus.pin_miso},    32'd0);
    check("reset_miso_en", {31'd0, bus.pin_miso_en}, 32'd0);
    check("reset_value",   {28'd0, bus.value_mosi},  32'd0);
    check("reset_valid",   n_valid,                  32'd0);

    // Basic frame
    v0 = n_valid; s0 = n_start; p0 = n_stop;
    frame(4'b1010, 4'b0110, got);
    check("t1_value_mosi", {28'd0, bus.value_mosi}, 32'h6);
    check("t1_miso",       {28'd0, got},            32'hA);
    check("t1_valid_cnt",  n_valid - v0,            32'd1);
    check("t1_start_cnt",  n_start - s0,            32'd1);
    check("t1_stop_cnt",   n_stop - p0,             32'd1);
    check("t1_miso_idle",  {30'd0, bus.pin_miso_en, bus.pin_miso}, 32'd0);

    // Walking / edge patterns
    for (int k = 0; k < 7; k++) begin
      frame(miso_tab[k], mosi_tab[k], got);
      check($sformatf("t2_mosi_%0d", k), {28'd0, bus.value_mosi}, {28'd0, mosi_tab[k]});
      check($sformatf("t2_miso_%0d", k), {28'd0, got},            {28'd0, miso_tab[k]});
    end

    // Partial frame: two SCK cycles then deselect
    v0 = n_valid; s0 = n_start; p0 = n_stop;
    bus.value_miso = 4'b1111;
    bus.pin_ncs = 1'b0;
    #100;
    for (int i = 0; i < 2; i++) begin
      bus.pin_mosi = 1'b1;
      #100 bus.pin_clk = 1'b1;
      #100 bus.pin_clk = 1'b0;
    end
    #100 bus.pin_ncs = 1'b1;
    #100;
    check("t3_start_cnt", n_start - s0,            32'd1);
    check("t3_stop_cnt",  n_stop - p0,             32'd1);
    check("t3_valid_cnt", n_valid - v0,            32'd0);
    check("t3_value_hold", {28'd0, bus.value_mosi}, 32'hE);

    // Two back-to-back words in one frame
    v0 = n_valid;
    bus.value_miso = 4'b0101;
    bus.pin_ncs = 1'b0;
    #100;
    xfer(4'b0011, 4'b1001, got);
    check("t4_first_mosi", {28'd0, bus.value_mosi}, 32'h3);
    xfer(4'b1100, 4'b1001, got2);
    #100 bus.pin_ncs = 1'b1;
    #100;
    check("t4_valid_cnt",  n_valid - v0,            32'd2);
    check("t4_miso_w0",    {28'd0, got},            32'h5);
    check("t4_miso_w1",    {28'd0, got2},           32'h9);
    check("t4_second_mosi", {28'd0, bus.value_mosi}, 32'hC);

    // Reset in the middle of a word
    v0 = n_valid; p0 = n_stop;
    bus.value_miso = 4'b1111;
    bus.pin_ncs = 1'b0;
    #100;
    for (int i = 0; i < 2; i++) begin
      bus.pin_mosi = 1'b1;
      #100 bus.pin_clk = 1'b1;
      #100 bus.pin_clk = 1'b0;
    end
    #50;
    rst = 1'b1;
    #2;
    check("t5_rst_miso",    {31'd0, bus.pin_miso},    32'd0);
    check("t5_rst_miso_en", {31'd0, bus.pin_miso_en}, 32'd0);
    check("t5_rst_value",   {28'd0, bus.value_mosi},  32'd0);
    check("t5_rst_flags",   {29'd0, bus.value_valid, bus.cs_start, bus.cs_stop}, 32'd0);
    bus.pin_ncs = 1'b1;
    #10 rst = 1'b0;
    #100;
    check("t5_no_valid", n_valid - v0, 32'd0);
    check("t5_no_stop",  n_stop - p0,  32'd0);
    frame(4'b1101, 4'b1011, got);
    check("t5_mosi", {28'd0, bus.value_mosi}, 32'hB);
    check("t5_miso", {28'd0, got},            32'hD);

    // SCK activity while deselected
    v0 = n_valid; s0 = n_start; p0 = n_stop;
    bus.value_miso = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      bus.pin_mosi = i[0];
      #100 bus.pin_clk = 1'b1;
      #50;
      check($sformatf("t6_idle_pins_%0d", i), {30'd0, bus.pin_miso_en, bus.pin_miso}, 32'd0);
      #50 bus.pin_clk = 1'b0;
    end
    #100;
    check("t6_valid_cnt", n_valid - v0, 32'd0);
    check("t6_start_cnt", n_start - s0, 32'd0);
    check("t6_stop_cnt",  n_stop - p0,  32'd0);
    check("t6_value_hold", {28'd0, bus.value_mosi}, 32'hB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
